// File: rtl/tbird_seq.sv
// Thunderbird tail-light sequencer: left/right thermometer sweeps plus hazard flash, with a built-in step prescaler.
// Latency: every output is registered, so a request shows on the lamps one tick after it is seen; busy follows the same edge.
// Backpressure: none; requests are levels. Optional BRAKE_EN adds a brake input that lights every non-sequencing side.
module tbird_seq #(
    parameter int N_LIGHTS = 3,
    parameter int STEP_DIV = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                left,
    input  logic                right,
    input  logic                hazard,
`ifdef BRAKE_EN
    input  logic                brake,
`endif
    output logic [N_LIGHTS-1:0] lights_l,
    output logic [N_LIGHTS-1:0] lights_r,
    output logic                busy
);

    localparam int SW = $clog2(N_LIGHTS + 1);
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

    state_t                state, state_n;
    logic [SW-1:0]         step, step_n;
    logic                  haz_on, haz_on_n;
    logic [PW-1:0]         pcnt;
    logic                  tick;
    logic [N_LIGHTS-1:0]   therm, base_l, base_r, out_l, out_r;
    logic                  brk;

    assign tick = (pcnt == PW'(STEP_DIV - 1));

`ifdef BRAKE_EN
    assign brk = brake;
`else
    assign brk = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        step_n   = step;
        haz_on_n = haz_on;
        if (tick) begin
            // Off phase of a side sequence re-evaluates requests exactly like IDLE.
            if (state == IDLE || ((state == LEFT || state == RIGHT) && (step == '0 || hazard))) begin
                haz_on_n = 1'b0;
                step_n   = '0;
                if (hazard || (left && right)) begin
                    state_n  = HAZ;
                    haz_on_n = 1'b1;
                end else if (left) begin
                    state_n = LEFT;
                    step_n  = SW'(1);
                end else if (right) begin
                    state_n = RIGHT;
                    step_n  = SW'(1);
                end else begin
                    state_n = IDLE;
                end
            end else if (state == LEFT || state == RIGHT) begin
                if (step < SW'(N_LIGHTS)) begin
                    step_n = step + SW'(1);
                end else begin
                    step_n  = '0;
                    state_n = ((state == LEFT) ? left : right) ? state : IDLE;
                end
            end else begin
                if (haz_on) begin
                    haz_on_n = 1'b0;
                end else if (hazard || (left && right)) begin
                    haz_on_n = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
        end
    end

    always_comb begin
        therm  = (N_LIGHTS'(1) << step_n) - N_LIGHTS'(1);
        base_l = '0;
        base_r = '0;
        case (state_n)
            LEFT:    base_l = therm;
            RIGHT:   base_r = therm;
            HAZ:     begin
                base_l = {N_LIGHTS{haz_on_n}};
                base_r = {N_LIGHTS{haz_on_n}};
            end
            default: ;
        endcase
        out_l = base_l | {N_LIGHTS{brk && state_n != LEFT && state_n != HAZ}};
        out_r = base_r | {N_LIGHTS{brk && state_n != RIGHT && state_n != HAZ}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            haz_on   <= 1'b0;
            pcnt     <= '0;
            lights_l <= '0;
            lights_r <= '0;
            busy     <= 1'b0;
        end else begin
            pcnt     <= tick ? '0 : pcnt + PW'(1);
            state    <= state_n;
            step     <= step_n;
            haz_on   <= haz_on_n;
            lights_l <= out_l;
            lights_r <= out_r;
            busy     <= (state_n != IDLE);
        end
    end

endmodule
